// File: rtl/uart_str_tx.sv
// Multi-byte 8N1 UART transmitter: latches a MulTXNum-byte word on request and
// sends it LSB-first as back-to-back frames, pulsing uart_txs_done at the end.
module uart_str_tx #(
  parameter int MulTXNum  = 3,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    uart_tx_req,
  input  logic [MulTXNum*8-1:0]   idats,
  output logic                    uart_txs_done,
  output logic                    uarttx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam int IW         = (MulTXNum > 1) ? $clog2(MulTXNum) : 1;
  localparam int DW         = MulTXNum * 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            bit_end;
  logic            last_byte;

  assign bit_end   = (baud_q == CW'(BIT_CYCLES - 1));
  assign last_byte = (idx_q == IW'(MulTXNum - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (uart_tx_req) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_q == 3'd7) state_d = STOP;
      STOP:    if (bit_end) state_d = last_byte ? DONE : START;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The shadow word doubles as the shift register: after eight data-bit shifts
  // the next byte already sits in the low bits, so no byte mux is needed.
  always_comb begin
    baud_d   = '0;
    bit_d    = bit_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (uart_tx_req) begin
          shadow_d = idats;
          idx_d    = '0;
        end
      end
      START, STOP: begin
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        bit_d  = '0;
        if (state_q == STOP && bit_end && !last_byte) idx_d = idx_q + IW'(1);
      end
      DATA: begin
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        if (bit_end) begin
          bit_d    = bit_q + 3'd1;
          shadow_d = shadow_q >> 1;
        end
      end
      default: begin
        bit_d = '0;
        idx_d = '0;
      end
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shadow_q[0];
      DONE:    done_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign uarttx        = tx_q;
  assign uart_txs_done = done_q;

endmodule

// File: tb/tb_uart_str_tx.sv
// Self-checking bench for uart_str_tx: a line decoder pops expected bytes from a
// scoreboard queue, plus timing checks on latency, done pulses and reset.
module tb_uart_str_tx;

  localparam int BIT = 434;
  localparam int NB  = 3;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        req     = 1'b0;
  logic [23:0] idats   = '0;
  logic        done;
  logic        tx;
  logic        req1    = 1'b0;
  logic [7:0]  idats1  = '0;
  logic        done1;
  logic        tx1;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int doneCnt = 0;
  bit monEn   = 1'b0;
  logic [7:0] expQ[$];

  uart_str_tx #(.MulTXNum(NB)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .uart_tx_req(req),
    .uart_txs_done(done), .idats(idats), .uarttx(tx)
  );

  uart_str_tx #(.MulTXNum(1)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .uart_tx_req(req1),
    .uart_txs_done(done1), .idats(idats1), .uarttx(tx1)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) if (done === 1'b1) doneCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] d, input bit hold, output int edgeCyc);
    @(negedge sys_clk);
    idats = d;
    req   = 1'b1;
    for (int k = 0; k < NB; k++) expQ.push_back(d[8*k +: 8]);
    @(posedge sys_clk);
    #1 edgeCyc = cyc;
    if (!hold) req = 1'b0;
  endtask

  task automatic waitDone(input bit which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if ((which ? done1 : done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput("done_seen", which ? done1 : done, 1);
  endtask

  // Decodes frames on the main line by mid-bit sampling and scores each byte.
  initial begin : lineMonitor
    logic       prev;
    logic [7:0] b;
    logic [7:0] e;
    prev = 1'b1;
    b    = '0;
    forever begin
      @(negedge sys_clk);
      if (monEn && prev === 1'b1 && tx === 1'b0) begin
        repeat (BIT / 2) @(negedge sys_clk);
        checkOutput("start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge sys_clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge sys_clk);
        checkOutput("stop_bit", tx, 1);
        if (expQ.size() == 0) begin
          checkOutput("sb_empty", expQ.size(), 1);
        end else begin
          e = expQ.pop_front();
          checkOutput("frame_byte", b, e);
        end
      end
      prev = tx;
    end
  end

  initial begin : mainSeq
    int reqEdge;
    int doneAt;
    int d1;
    int d2;
    logic [9:0] pat;

    repeat (3) @(negedge sys_clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_done", done, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Reset hit in the middle of a frame must force the line high at once.
    @(negedge sys_clk);
    idats = 24'h002FE0;
    req   = 1'b1;
    @(negedge sys_clk);
    req = 1'b0;
    repeat (1000) @(negedge sys_clk);
    checkOutput("midframe_bit", tx, 0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tx", tx, 1);
    checkOutput("async_rst_done", done, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      checkOutput("idle_after_rst", tx, 1);
    end
    checkOutput("no_done_after_rst", doneCnt, 0);

    monEn = 1'b1;

    applyStimulus(24'h002FE0, 1'b0, reqEdge);
    checkOutput("lat_hold", tx, 1);
    @(posedge sys_clk);
    #1 checkOutput("lat_fall", tx, 0);
    waitDone(1'b0, 20000, doneAt);
    checkOutput("done_time", doneAt - reqEdge, 30 * BIT + 1);
    @(negedge sys_clk);
    checkOutput("done_width", done, 0);
    checkOutput("sb_drained1", expQ.size(), 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      checkOutput("idle_between", tx, 1);
    end

    // Held request: back-to-back transfers; idats change mid-transfer only
    // affects the following transfer.
    applyStimulus(24'h002FE0, 1'b1, reqEdge);
    repeat (2000) @(negedge sys_clk);
    idats = 24'hFFFFFF;
    for (int k = 0; k < NB; k++) expQ.push_back(8'hFF);
    waitDone(1'b0, 20000, d1);
    checkOutput("gap_done_cycle", tx, 1);
    @(negedge sys_clk);
    checkOutput("gap_idle_cycle", tx, 1);
    @(negedge sys_clk);
    checkOutput("gap_restart", tx, 0);
    repeat (3000) @(negedge sys_clk);
    req = 1'b0;
    waitDone(1'b0, 20000, d2);
    checkOutput("done_period", d2 - d1, 30 * BIT + 2);
    repeat (13100) @(negedge sys_clk);
    checkOutput("no_extra_done", doneCnt, 3);
    checkOutput("sb_drained2", expQ.size(), 0);
    checkOutput("final_idle", tx, 1);

    // Single-byte variant: 0xA5 framed as 0,1,0,1,0,0,1,0,1,1 (time order).
    pat = 10'b11_0100_1010;
    @(negedge sys_clk);
    idats1 = 8'hA5;
    req1   = 1'b1;
    @(posedge sys_clk);
    #1 reqEdge = cyc;
    req1 = 1'b0;
    @(posedge sys_clk);
    repeat (BIT / 2) @(negedge sys_clk);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("a5_bit%0d", k), tx1, pat[k]);
      if (k < 9) repeat (BIT) @(negedge sys_clk);
    end
    waitDone(1'b1, 6000, doneAt);
    checkOutput("done1_time", doneAt - reqEdge, 10 * BIT + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
